// File: rtl/vga_timing_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_timing_pkg : 800x600 @ 60 Hz VGA timing defaults and window helpers
// Revision       : 1.0
// ============================================================================
package vga_timing_pkg;

   localparam int unsigned c_CNT_W = 11;
   typedef logic [c_CNT_W-1:0] coord_t;

   localparam int unsigned c_H_SYNC   = 128;
   localparam int unsigned c_H_BACK   = 88;
   localparam int unsigned c_H_ACTIVE = 800;
   localparam int unsigned c_H_FRONT  = 40;

   localparam int unsigned c_V_SYNC   = 4;
   localparam int unsigned c_V_BACK   = 23;
   localparam int unsigned c_V_ACTIVE = 600;
   localparam int unsigned c_V_FRONT  = 1;

   localparam coord_t c_COORD_INVALID = 11'h7FF;

   function automatic int unsigned axis_total(input int unsigned sync, back, active, front);
      return sync + back + active + front;
   endfunction

   function automatic int unsigned act_start(input int unsigned sync, back);
      return sync + back;
   endfunction

   function automatic int unsigned act_end(input int unsigned sync, back, active);
      return sync + back + active - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_axis_counter : wrap-around raster counter with sync/active decode
// Revision         : 1.0
// ============================================================================
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int unsigned TOTAL     = 1056,
   parameter int unsigned SYNC_LEN  = 128,
   parameter int unsigned ACT_START = 216,
   parameter int unsigned ACT_END   = 1015
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   en_i,
   output coord_t count_o,
   output logic   in_sync_o,
   output logic   in_active_o
);

   coord_t count_q;
   coord_t count_d;
   logic   w_at_end;

   assign w_at_end = (count_q == coord_t'(TOTAL - 1));

   always_comb begin
      count_d = count_q;
      if (en_i) begin
         count_d = w_at_end ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o     = count_q;
   assign in_sync_o   = (count_q < coord_t'(SYNC_LEN));
   assign in_active_o = (count_q >= coord_t'(ACT_START)) && (count_q <= coord_t'(ACT_END));

endmodule
`default_nettype wire

// File: rtl/vga_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// vga_sync_ctrl : VGA raster timing generator with early pixel request
// Revision      : 1.0
// ============================================================================
module vga_sync_ctrl
   import vga_timing_pkg::*;
#(
   parameter int unsigned H_SYNC   = c_H_SYNC,
   parameter int unsigned H_BACK   = c_H_BACK,
   parameter int unsigned H_ACTIVE = c_H_ACTIVE,
   parameter int unsigned H_FRONT  = c_H_FRONT,
   parameter int unsigned V_SYNC   = c_V_SYNC,
   parameter int unsigned V_BACK   = c_V_BACK,
   parameter int unsigned V_ACTIVE = c_V_ACTIVE,
   parameter int unsigned V_FRONT  = c_V_FRONT,
   parameter bit          SYNC_POL = 1'b1
) (
   input  logic        vga_clk,
   input  logic        sys_rst,
   input  logic [2:0]  pix_data,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic        hsync,
   output logic        vsync,
   output logic [2:0]  vga_rgb
);

   localparam int unsigned H_TOTAL     = axis_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
   localparam int unsigned V_TOTAL     = axis_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
   localparam int unsigned H_ACT_START = act_start(H_SYNC, H_BACK);
   localparam int unsigned H_ACT_END   = act_end(H_SYNC, H_BACK, H_ACTIVE);
   localparam int unsigned V_ACT_START = act_start(V_SYNC, V_BACK);
   localparam int unsigned V_ACT_END   = act_end(V_SYNC, V_BACK, V_ACTIVE);

   coord_t w_h_cnt;
   coord_t w_v_cnt;
   logic   w_h_wrap;
   logic   w_h_in_sync;
   logic   w_v_in_sync;
   logic   w_h_in_active;
   logic   w_v_in_active;
   logic   w_h_in_req;
   logic   w_req;

   assign w_h_wrap = (w_h_cnt == coord_t'(H_TOTAL - 1));

   vga_axis_counter #(
      .TOTAL     (H_TOTAL),
      .SYNC_LEN  (H_SYNC),
      .ACT_START (H_ACT_START),
      .ACT_END   (H_ACT_END)
   ) u_h_cnt (
      .clk_i       (vga_clk),
      .rst_i       (sys_rst),
      .en_i        (1'b1),
      .count_o     (w_h_cnt),
      .in_sync_o   (w_h_in_sync),
      .in_active_o (w_h_in_active)
   );

   vga_axis_counter #(
      .TOTAL     (V_TOTAL),
      .SYNC_LEN  (V_SYNC),
      .ACT_START (V_ACT_START),
      .ACT_END   (V_ACT_END)
   ) u_v_cnt (
      .clk_i       (vga_clk),
      .rst_i       (sys_rst),
      .en_i        (w_h_wrap),
      .count_o     (w_v_cnt),
      .in_sync_o   (w_v_in_sync),
      .in_active_o (w_v_in_active)
   );

   // Request one pixel ahead so the source's registered data lands on its column.
   assign w_h_in_req = (w_h_cnt >= coord_t'(H_ACT_START - 1)) &&
                       (w_h_cnt <= coord_t'(H_ACT_END - 1));
   assign w_req      = w_h_in_req & w_v_in_active;

   assign pix_x   = w_req ? (w_h_cnt - coord_t'(H_ACT_START - 1)) : c_COORD_INVALID;
   assign pix_y   = w_req ? (w_v_cnt - coord_t'(V_ACT_START))     : c_COORD_INVALID;
   assign hsync   = w_h_in_sync ? SYNC_POL : ~SYNC_POL;
   assign vsync   = w_v_in_sync ? SYNC_POL : ~SYNC_POL;
   assign vga_rgb = (w_h_in_active & w_v_in_active) ? pix_data : 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_vga_sync_ctrl : directed checks of the VGA timing generator
// Revision         : 1.0
// ============================================================================
module tb_vga_sync_ctrl;

   // u_dut_a uses full 800x600 timing; u_dut_b shrinks only the vertical axis
   // (2 sync, 3 back, 4 active, 1 front = 10 lines) so whole frames stay short.
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          src_mode = 2;
   logic [2:0]  data_a, data_b;
   logic [10:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b;
   logic        hsync_a, vsync_a, hsync_b, vsync_b;
   logic [2:0]  rgb_a, rgb_b;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 clk = ~clk;

   vga_sync_ctrl u_dut_a (
      .vga_clk  (clk),
      .sys_rst  (rst),
      .pix_data (data_a),
      .pix_x    (pix_x_a),
      .pix_y    (pix_y_a),
      .hsync    (hsync_a),
      .vsync    (vsync_a),
      .vga_rgb  (rgb_a)
   );

   vga_sync_ctrl #(
      .V_SYNC   (2),
      .V_BACK   (3),
      .V_ACTIVE (4),
      .V_FRONT  (1)
   ) u_dut_b (
      .vga_clk  (clk),
      .sys_rst  (rst),
      .pix_data (data_b),
      .pix_x    (pix_x_b),
      .pix_y    (pix_y_b),
      .hsync    (hsync_b),
      .vsync    (vsync_b),
      .vga_rgb  (rgb_b)
   );

   // Pixel source: registers a colour one cycle after reading the coordinate.
   always @(posedge clk) begin
      data_a <= (src_mode == 1) ? pix_x_a[2:0] : 3'b111;
      data_b <= (src_mode == 1) ? pix_x_b[2:0] : 3'b111;
   end

   task automatic step();
      @(negedge clk);
   endtask

   // After this returns, outputs reflect h_cnt = v_cnt = 0 (sample index 0).
   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      n_checks++; if (hsync_a !== 1'b1) begin n_fail++; $display("FAIL reset_hsync: got %b expected 1", hsync_a); end
      n_checks++; if (vsync_a !== 1'b1) begin n_fail++; $display("FAIL reset_vsync: got %b expected 1", vsync_a); end
      n_checks++; if (pix_x_a !== 11'h7FF) begin n_fail++; $display("FAIL reset_pix_x: got %h expected 7ff", pix_x_a); end
      n_checks++; if (pix_y_a !== 11'h7FF) begin n_fail++; $display("FAIL reset_pix_y: got %h expected 7ff", pix_y_a); end
      n_checks++; if (rgb_a !== 3'b000) begin n_fail++; $display("FAIL reset_rgb: got %b expected 000", rgb_a); end
      n_checks++; if (vsync_b !== 1'b1) begin n_fail++; $display("FAIL reset_vsync_b: got %b expected 1", vsync_b); end
      rst = 1'b0;
      n_checks++; if (hsync_a !== 1'b1) begin n_fail++; $display("FAIL release_hsync: got %b expected 1", hsync_a); end
      step();
      n_checks++; if (hsync_a !== 1'b1) begin n_fail++; $display("FAIL release_hsync_c1: got %b expected 1", hsync_a); end
   endtask

   task automatic test_horizontal();
      int   hi0 = 0, hi1 = 0, rise = -1, req = 0;
      logic prev;
      do_reset(2);
      prev = hsync_a;
      for (int i = 0; i < 2112; i++) begin
         if (hsync_a === 1'b1) begin
            if (i < 1056) hi0++; else hi1++;
         end
         if (prev === 1'b0 && hsync_a === 1'b1 && rise < 0) rise = i;
         if (pix_x_a !== 11'h7FF) req++;
         prev = hsync_a;
         step();
      end
      n_checks++; if (hi0 != 128) begin n_fail++; $display("FAIL hsync_width_l0: got %0d expected 128", hi0); end
      n_checks++; if (hi1 != 128) begin n_fail++; $display("FAIL hsync_width_l1: got %0d expected 128", hi1); end
      n_checks++; if (rise != 1056) begin n_fail++; $display("FAIL hsync_period: got %0d expected 1056", rise); end
      n_checks++; if (req != 0) begin n_fail++; $display("FAIL no_req_in_vsync: got %0d requests expected 0", req); end
   endtask

   task automatic test_vertical();
      int   vhi_a = 0, vhi_b = 0, r1 = -1, r2 = -1;
      logic prev_b;
      do_reset(2);
      prev_b = vsync_b;
      for (int i = 0; i < 29568; i++) begin
         int h, ln, exp_y;
         h  = i % 1056;
         ln = i / 1056;
         if (vsync_a === 1'b1) vhi_a++;
         if (i < 10560 && vsync_b === 1'b1) vhi_b++;
         if (prev_b === 1'b0 && vsync_b === 1'b1) begin
            if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
         end
         prev_b = vsync_b;
         if (ln == 26 && h == 215) begin
            n_checks++; if (pix_x_a !== 11'h7FF) begin n_fail++; $display("FAIL porch_line_pix_x: got %h expected 7ff", pix_x_a); end
         end
         if (ln == 27) begin
            if (h == 214) begin
               n_checks++; if (pix_x_a !== 11'h7FF) begin n_fail++; $display("FAIL pix_x_h214: got %h expected 7ff", pix_x_a); end
            end
            if (h == 215) begin
               n_checks++; if (pix_x_a !== 11'd0) begin n_fail++; $display("FAIL pix_x_first: got %0d expected 0", pix_x_a); end
               n_checks++; if (pix_y_a !== 11'd0) begin n_fail++; $display("FAIL pix_y_first: got %0d expected 0", pix_y_a); end
            end
            if (h == 1014) begin
               n_checks++; if (pix_x_a !== 11'd799) begin n_fail++; $display("FAIL pix_x_last: got %0d expected 799", pix_x_a); end
            end
            if (h == 1015) begin
               n_checks++; if (pix_x_a !== 11'h7FF) begin n_fail++; $display("FAIL pix_x_h1015: got %h expected 7ff", pix_x_a); end
               n_checks++; if (pix_y_a !== 11'h7FF) begin n_fail++; $display("FAIL pix_y_h1015: got %h expected 7ff", pix_y_a); end
            end
         end
         if (ln < 11 && h == 600) begin
            exp_y = (ln >= 5 && ln <= 8) ? ln - 5 : 'h7FF;
            n_checks++;
            if (pix_y_b !== 11'(exp_y)) begin
               n_fail++; $display("FAIL pix_y_b_line%0d: got %h expected %h", ln, pix_y_b, 11'(exp_y));
            end
         end
         step();
      end
      n_checks++; if (vhi_a != 4224) begin n_fail++; $display("FAIL vsync_width: got %0d expected 4224", vhi_a); end
      n_checks++; if (vhi_b != 2112) begin n_fail++; $display("FAIL vsync_b_width: got %0d expected 2112", vhi_b); end
      n_checks++; if (r1 != 10560) begin n_fail++; $display("FAIL vsync_b_wrap: got %0d expected 10560", r1); end
      n_checks++; if (r2 - r1 != 10560) begin n_fail++; $display("FAIL vsync_b_period: got %0d expected 10560", r2 - r1); end
   endtask

   task automatic test_data_path();
      int cnt_b [10];
      int nz_a = 0;
      for (int j = 0; j < 10; j++) cnt_b[j] = 0;
      src_mode = 2;
      do_reset(2);
      for (int i = 0; i < 10560; i++) begin
         int h, ln;
         h  = i % 1056;
         ln = i / 1056;
         if (rgb_b === 3'b111) cnt_b[ln]++;
         if (rgb_a !== 3'b000) nz_a++;
         if (ln == 5 && h == 215) begin
            n_checks++; if (rgb_b !== 3'b000) begin n_fail++; $display("FAIL rgb_h215: got %b expected 000", rgb_b); end
         end
         if (ln == 5 && h == 216) begin
            n_checks++; if (rgb_b !== 3'b111) begin n_fail++; $display("FAIL rgb_h216: got %b expected 111", rgb_b); end
         end
         if (ln == 5 && h == 1015) begin
            n_checks++; if (rgb_b !== 3'b111) begin n_fail++; $display("FAIL rgb_h1015: got %b expected 111", rgb_b); end
         end
         if (ln == 5 && h == 1016) begin
            n_checks++; if (rgb_b !== 3'b000) begin n_fail++; $display("FAIL rgb_h1016: got %b expected 000", rgb_b); end
         end
         step();
      end
      for (int j = 0; j < 10; j++) begin
         n_checks++;
         if (cnt_b[j] != ((j >= 5 && j <= 8) ? 800 : 0)) begin
            n_fail++; $display("FAIL rgb_count_line%0d: got %0d expected %0d", j, cnt_b[j], (j >= 5 && j <= 8) ? 800 : 0);
         end
      end
      n_checks++; if (nz_a != 0) begin n_fail++; $display("FAIL rgb_blank_porch: got %0d lit cycles expected 0", nz_a); end
   endtask

   task automatic test_mapping();
      src_mode = 1;
      do_reset(2);
      repeat (5 * 1056 + 216) step();
      n_checks++; if (rgb_b !== 3'd0) begin n_fail++; $display("FAIL map_col0: got %0d expected 0", rgb_b); end
      step();
      n_checks++; if (rgb_b !== 3'd1) begin n_fail++; $display("FAIL map_col1: got %0d expected 1", rgb_b); end
      repeat (6) step();
      n_checks++; if (rgb_b !== 3'd7) begin n_fail++; $display("FAIL map_col7: got %0d expected 7", rgb_b); end
      step();
      n_checks++; if (rgb_b !== 3'd0) begin n_fail++; $display("FAIL map_col8: got %0d expected 0", rgb_b); end
      repeat (1015 - 224) step();
      n_checks++; if (rgb_b !== 3'd7) begin n_fail++; $display("FAIL map_col799: got %0d expected 7", rgb_b); end
      step();
      n_checks++; if (rgb_b !== 3'd0) begin n_fail++; $display("FAIL map_after_last: got %0d expected 0", rgb_b); end
   endtask

   task automatic test_mid_frame_reset();
      int   hfall = -1, vfall = -1, vrise = -1;
      logic prev_v;
      src_mode = 2;
      do_reset(2);
      repeat (7 * 1056 + 500) step();
      n_checks++; if (pix_x_b !== 11'd285) begin n_fail++; $display("FAIL pre_rst_pix_x: got %0d expected 285", pix_x_b); end
      n_checks++; if (pix_y_b !== 11'd2) begin n_fail++; $display("FAIL pre_rst_pix_y: got %0d expected 2", pix_y_b); end
      n_checks++; if (rgb_b !== 3'b111) begin n_fail++; $display("FAIL pre_rst_rgb: got %b expected 111", rgb_b); end
      rst = 1'b1;
      step();
      n_checks++; if (hsync_b !== 1'b1) begin n_fail++; $display("FAIL mid_rst_hsync: got %b expected 1", hsync_b); end
      n_checks++; if (vsync_b !== 1'b1) begin n_fail++; $display("FAIL mid_rst_vsync: got %b expected 1", vsync_b); end
      n_checks++; if (pix_x_b !== 11'h7FF) begin n_fail++; $display("FAIL mid_rst_pix_x: got %h expected 7ff", pix_x_b); end
      n_checks++; if (pix_y_b !== 11'h7FF) begin n_fail++; $display("FAIL mid_rst_pix_y: got %h expected 7ff", pix_y_b); end
      n_checks++; if (rgb_b !== 3'b000) begin n_fail++; $display("FAIL mid_rst_rgb: got %b expected 000", rgb_b); end
      rst = 1'b0;
      prev_v = vsync_b;
      for (int i = 0; i <= 10560; i++) begin
         if (hsync_b === 1'b0 && hfall < 0) hfall = i;
         if (vsync_b === 1'b0 && vfall < 0) vfall = i;
         if (prev_v === 1'b0 && vsync_b === 1'b1 && vrise < 0) vrise = i;
         prev_v = vsync_b;
         if (i == 5 * 1056 + 215) begin
            n_checks++; if (pix_x_b !== 11'd0) begin n_fail++; $display("FAIL post_rst_pix_x: got %0d expected 0", pix_x_b); end
         end
         step();
      end
      n_checks++; if (hfall != 128) begin n_fail++; $display("FAIL post_rst_hsync_fall: got %0d expected 128", hfall); end
      n_checks++; if (vfall != 2112) begin n_fail++; $display("FAIL post_rst_vsync_fall: got %0d expected 2112", vfall); end
      n_checks++; if (vrise != 10560) begin n_fail++; $display("FAIL post_rst_frame: got %0d expected 10560", vrise); end
   endtask

   initial begin
      test_reset();
      test_horizontal();
      test_vertical();
      test_data_path();
      test_mapping();
      test_mid_frame_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/vga_sync_ctrl.md
Name: vga_sync_ctrl

Overview:
- VGA raster timing generator for 800x600 @ 60 Hz (40 MHz pixel clock, supplied by an external PLL in the top level).
- Produces hsync, vsync and a one-cycle-early pixel coordinate request (pix_x/pix_y) to the pixel source.
- Gates the returned pix_data onto vga_rgb only inside the visible area.
- Sits between the pixel-clock PLL and the VGA connector; the upstream pixel generator registers pix_data one cycle after reading pix_x/pix_y.

Parameters:
- H_SYNC, 128, hsync pulse width (pixels)
- H_BACK, 88, horizontal back porch
- H_ACTIVE, 800, visible pixels per line
- H_FRONT, 40, horizontal front porch
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch
- V_ACTIVE, 600, visible lines per frame
- V_FRONT, 1, vertical front porch
- SYNC_POL, 1, sync polarity during pulse (1 = active-high pulse)
- Derived, not overridable: H_TOTAL = 1056, V_TOTAL = 628.

Ports:
- vga_clk  in  1  pixel clock, 40 MHz; the only clock
- sys_rst  in  1  synchronous, active-high reset, sampled on rising vga_clk (top level drives it from ~(sys_rstn & pll_locked))
- pix_data  in  3  RGB pixel from the source, valid one cycle after the matching pix_x/pix_y
- pix_x  out  11  requested column 0..799; 11'h7FF when no request
- pix_y  out  11  requested row 0..599; 11'h7FF when no request
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- vga_rgb  out  3  pixel to DAC/pins; 3'b000 outside the visible area

Behaviour:
- Counters:
  - h_cnt (11 b) counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt (11 b) increments only when h_cnt == H_TOTAL-1, counts 0..V_TOTAL-1 and wraps to 0.
  - Both counters are registered; every output is combinational from the counters plus pix_data.
- Segment order per axis: sync, back porch, active, front porch.
- hsync = SYNC_POL while h_cnt < H_SYNC, else ~SYNC_POL.
- vsync = SYNC_POL while v_cnt < V_SYNC, else ~SYNC_POL.
- Visible area:
  - h_cnt in [216, 1015] and v_cnt in [27, 626].
  - Generally: [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and the vertical equivalent.
- Request window:
  - Horizontal range is shifted one cycle earlier: h_cnt in [215, 1014].
  - Vertical range is the same as the visible area: v_cnt in [27, 626].
- Inside the request window:
  - pix_x = h_cnt - 215.
  - pix_y = v_cnt - 27.
- Outside the request window: pix_x = pix_y = 11'h7FF, both together.
- vga_rgb = pix_data inside the visible area, else 3'b000.
  - This yields zero net latency from pix_x = N to that pixel's colour appearing at visible column N.
- Reset (sys_rst = 1 at a rising edge):
  - h_cnt = v_cnt = 0.
  - Outputs in reset: hsync = vsync = SYNC_POL, pix_x = pix_y = 11'h7FF, vga_rgb = 0.
  - Reset asserted mid-frame aborts the frame; counting restarts at (0,0) on the first edge after release.
- Boundaries:
  - pix_x runs 0..799 contiguously; at h_cnt = 1015 it returns to 7FF.
  - Last visible line is v_cnt = 626; v_cnt = 627 is front porch; frame wraps to v_cnt = 0.
  - pix_data arriving outside the visible area is ignored.
- Frame length: 1056 x 628 = 663,168 cycles.

Decomposition:
- Package vga_timing_pkg:
  - 800x600 timing constants (sync, porch and active values for both axes).
  - Derived totals and window start/end values.
  - Localparam for the invalid coordinate (11'h7FF).
- One natural sub-module: vga_axis_counter.
  - Parameterised wrap-around counter with an enable input.
  - Outputs: count, in_sync, in_active.
  - Instantiated once for the horizontal axis (enable = 1) and once for the vertical axis (enable = horizontal wrap).

Test Plan:
- Reset: hold sys_rst 5 cycles -> hsync = vsync = 1, pix_x = pix_y = 7FF, vga_rgb = 0; first cycle after release h_cnt = 0 and hsync = 1.
- Horizontal timing: run 2 lines -> hsync high exactly 128 cycles, period 1056 cycles; pix_x = 0 appears 215 cycles after the hsync rising edge on visible lines.
- Vertical timing: run 1 full frame -> vsync high exactly 4 x 1056 = 4224 cycles, period 663,168 cycles; pix_y steps 0..599 with 600 distinct values.
- Data path: source registers pix_data = 3'b111 whenever pix_x < 800 and pix_y < 600 -> vga_rgb = 111 for exactly 800 cycles per visible line (h_cnt 216..1015) and 0 elsewhere, including porch lines.
- Coordinate mapping: source returns pix_x[2:0] -> vga_rgb at visible column N equals N mod 8 for N = 0, 1, 799.
- Mid-frame reset: assert sys_rst at v_cnt = 300, h_cnt = 500 for 1 cycle -> outputs return to reset values; next hsync and vsync pulses start at release; full-frame period thereafter.
